// File: rtl/btn_pkg.sv
// Shared definitions for the button event arbiter: FSM encoding, default
// sizing and the holdoff counter width helper.
package btn_pkg;

    localparam int DEF_N_BTN   = 4;
    localparam int DEF_HOLDOFF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFER  = 2'd1,
        ST_HLDOFF = 2'd2
    } state_t;

    // A zero holdoff still needs a one-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int holdoff);
        return (holdoff > 0) ? $clog2(holdoff + 1) : 1;
    endfunction

endpackage

// File: rtl/button_event_arbiter_rr_pick.sv
// Combinational round-robin finder: returns the first set request bit found
// searching upward from last+1 with wrap-around.
module rr_pick #(
    parameter int N_BTN = 4,
    parameter int IDW   = 2
) (
    input  logic [N_BTN-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic [IDW-1:0]   gnt_id,
    output logic             any
);

    logic [IDW-1:0]   w_idx [N_BTN];
    logic [N_BTN-1:0] w_hit;

    // Candidate gi is the button gi+1 positions after the last grant.
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_cand
        logic [IDW:0] w_sum;
        assign w_sum       = {1'b0, last} + (IDW+1)'(gi + 1);
        assign w_idx[gi]   = (w_sum >= (IDW+1)'(N_BTN)) ? IDW'(w_sum - (IDW+1)'(N_BTN))
                                                         : IDW'(w_sum);
        assign w_hit[gi]   = req[w_idx[gi]];
    end

    always_comb begin
        any    = |req;
        gnt_id = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                gnt_id = w_idx[k];
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Turns debounced button presses into one-shot events, latches them as pending
// requests and offers them one at a time, round-robin, with a holdoff gap.
module button_event_arbiter
    import btn_pkg::*;
#(
    parameter int N_BTN   = DEF_N_BTN,
    parameter int HOLDOFF = DEF_HOLDOFF,
    parameter int IDW     = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_clean,
    output logic             evt_valid,
    output logic [IDW-1:0]   evt_id,
    input  logic             evt_ready,
    output logic [N_BTN-1:0] pending,
    output logic             overrun
);

    localparam int             CW        = cnt_width(HOLDOFF);
    localparam logic [CW-1:0]  HOLD_LOAD = CW'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);
    localparam logic [IDW-1:0] LAST_RST  = IDW'(N_BTN - 1);

    logic [N_BTN-1:0] r_btn_q;
    logic [N_BTN-1:0] r_pending;
    logic             r_overrun;
    state_t           r_state;
    logic             r_evt_valid;
    logic [IDW-1:0]   r_evt_id;
    logic [IDW-1:0]   r_last_grant;
    logic [CW-1:0]    r_cnt;

    state_t           w_state_next;
    logic             w_evt_valid_next;
    logic [IDW-1:0]   w_evt_id_next;
    logic [IDW-1:0]   w_last_next;
    logic [CW-1:0]    w_cnt_next;

    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_acc_mask;
    logic [N_BTN-1:0] w_pending_next;
    logic             w_overrun_next;
    logic             w_accept;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_any;

    assign w_rise   = btn_clean & ~r_btn_q;
    assign w_accept = r_evt_valid & evt_ready;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_acc
        assign w_acc_mask[gi] = w_accept && (r_evt_id == IDW'(gi));
    end

    // A fresh rise always wins over a same-cycle accept, so no press is lost there.
    assign w_pending_next = w_rise | (r_pending & ~w_acc_mask);
    assign w_overrun_next = |(w_rise & r_pending & ~w_acc_mask);

    rr_pick #(
        .N_BTN (N_BTN),
        .IDW   (IDW)
    ) u_pick (
        .req    (r_pending),
        .last   (r_last_grant),
        .gnt_id (w_gnt_id),
        .any    (w_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_q   <= '0;
            r_pending <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_btn_q   <= btn_clean;
            r_pending <= w_pending_next;
            r_overrun <= w_overrun_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_evt_valid  <= 1'b0;
            r_evt_id     <= '0;
            r_last_grant <= LAST_RST;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_evt_valid  <= w_evt_valid_next;
            r_evt_id     <= w_evt_id_next;
            r_last_grant <= w_last_next;
            r_cnt        <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_any)        w_state_next = ST_OFFER;
            ST_OFFER:  if (evt_ready)    w_state_next = (HOLDOFF > 0) ? ST_HLDOFF : ST_IDLE;
            ST_HLDOFF: if (r_cnt == '0)  w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_evt_valid_next = r_evt_valid;
        w_evt_id_next    = r_evt_id;
        w_last_next      = r_last_grant;
        w_cnt_next       = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_evt_valid_next = w_any;
                if (w_any) begin
                    w_evt_id_next = w_gnt_id;
                end
            end
            ST_OFFER: begin
                w_evt_valid_next = 1'b1;
                if (evt_ready) begin
                    w_evt_valid_next = 1'b0;
                    w_last_next      = r_evt_id;
                    w_cnt_next       = HOLD_LOAD;
                end
            end
            ST_HLDOFF: begin
                w_evt_valid_next = 1'b0;
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_evt_valid_next = 1'b0;
            end
        endcase
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign pending   = r_pending;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench: a cycle-level reference model predicts pending/overrun and
// queues each expected event offer; a monitor pops and checks at every offer.
module tb_button_event_arbiter;

    localparam int N   = 4;
    localparam int H   = 16;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   btn_clean;
    logic           evt_ready;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic [N-1:0]   pending;
    logic           overrun;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .N_BTN   (N),
        .HOLDOFF (H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_clean (btn_clean),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .pending   (pending),
        .overrun   (overrun)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ovr_cnt = 0;
    int evt_cnt = 0;

    typedef struct {
        int id;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    bit [N-1:0] m_prev     = '0;
    bit [N-1:0] m_pend     = '0;
    bit [N-1:0] m_rise     = '0;
    bit [N-1:0] m_accm     = '0;
    bit [N-1:0] m_old_pend = '0;
    bit         m_valid    = 1'b0;
    bit         m_ovr      = 1'b0;
    bit         m_acc      = 1'b0;
    int         m_id       = 0;
    int         m_last     = N - 1;
    int         m_earliest = 0;
    int         m_g        = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int pick(input bit [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: state after each edge; edge index is cyc+1.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_prev     = '0;
            m_pend     = '0;
            m_valid    = 1'b0;
            m_ovr      = 1'b0;
            m_id       = 0;
            m_last     = N - 1;
            m_earliest = 0;
            exp_q.delete();
        end else begin
            m_acc  = m_valid && evt_ready;
            m_accm = '0;
            if (m_acc) m_accm[m_id] = 1'b1;
            m_rise     = btn_clean & ~m_prev;
            m_prev     = btn_clean;
            m_ovr      = |(m_rise & m_pend & ~m_accm);
            m_old_pend = m_pend;
            m_pend     = m_rise | (m_pend & ~m_accm);
            if (m_acc) begin
                m_valid    = 1'b0;
                m_last     = m_id;
                m_earliest = cyc + 1 + H + 1;
            end else if (!m_valid && (cyc + 1) >= m_earliest && m_old_pend != '0) begin
                m_g     = pick(m_old_pend, m_last);
                m_valid = 1'b1;
                m_id    = m_g;
                exp_q.push_back('{m_g, cyc + 1});
            end
        end
    end

    bit   prev_v = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        chk("valid", int'(evt_valid), int'(m_valid));
        chk("pending", int'(pending), int'(m_pend));
        chk("overrun", int'(overrun), int'(m_ovr));
        if (m_valid) chk("evt_id", int'(evt_id), m_id);
        if (overrun) ovr_cnt++;
        if (evt_valid && !prev_v) begin
            evt_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual id %0d required no event (cycle %0d)", evt_id, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_id", int'(evt_id), e.id);
                chk("sb_cycle", cyc, e.cyc);
            end
        end
        prev_v = evt_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cyc);
        int n = 0;
        while (!evt_valid && n < max_cyc) begin
            tick(1);
            n++;
        end
        if (!evt_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid actual timeout required evt_valid within %0d cycles", max_cyc);
        end
    endtask

    int base_o;
    int base_e;

    initial begin
        reset     = 1'b0;
        btn_clean = '0;
        evt_ready = 1'b1;
        tick(5);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_pending", int'(pending), 0);
        reset = 1'b1;

        // Single press on button 2
        tick(5);
        btn_clean[2] = 1'b1;
        wait_valid(10);
        chk("t1_id", int'(evt_id), 2);
        tick(40);
        btn_clean = '0;

        // Simultaneous presses on 0, 1 and 3, then a fresh press on 0
        tick(5);
        btn_clean = 4'b1011;
        tick(70);
        btn_clean = '0;
        tick(3);
        btn_clean[0] = 1'b1;
        tick(25);
        btn_clean = '0;
        tick(20);

        // Stalled consumer plus an overrun on button 1
        evt_ready    = 1'b0;
        btn_clean[1] = 1'b1;
        wait_valid(10);
        chk("t3_id", int'(evt_id), 1);
        btn_clean[1] = 1'b0;
        tick(2);
        base_o = ovr_cnt;
        base_e = evt_cnt;
        btn_clean[1] = 1'b1;
        tick(20);
        chk("t4_ovr_pulses", ovr_cnt - base_o, 1);
        chk("t4_pending1", int'(pending[1]), 1);
        evt_ready = 1'b1;
        tick(30);
        chk("t4_events", evt_cnt - base_e, 0);
        btn_clean = '0;
        tick(5);

        // Re-press on the accept cycle
        evt_ready    = 1'b0;
        btn_clean[2] = 1'b1;
        wait_valid(10);
        btn_clean[2] = 1'b0;
        tick(2);
        base_o = ovr_cnt;
        base_e = evt_cnt;
        btn_clean[2] = 1'b1;
        evt_ready    = 1'b1;
        tick(40);
        chk("t5_ovr", ovr_cnt - base_o, 0);
        chk("t5_events", evt_cnt - base_e, 1);
        btn_clean = '0;
        tick(5);

        // Button 3 held through reset
        btn_clean[3] = 1'b1;
        reset        = 1'b0;
        tick(4);
        reset  = 1'b1;
        base_e = evt_cnt;
        wait_valid(10);
        chk("t6_id", int'(evt_id), 3);
        tick(30);
        chk("t6_events", evt_cnt - base_e, 1);
        btn_clean = '0;
        tick(5);

        // Asynchronous reset while offering
        evt_ready    = 1'b0;
        btn_clean[0] = 1'b1;
        wait_valid(10);
        #2;
        reset = 1'b0;
        #1;
        chk("t7_async_valid", int'(evt_valid), 0);
        chk("t7_async_pending", int'(pending), 0);
        @(posedge clk);
        #1;
        tick(2);
        btn_clean = '0;
        evt_ready = 1'b1;
        reset     = 1'b1;
        tick(5);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) btn_clean[i] = ~btn_clean[i];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                tick(2);
                reset = 1'b1;
            end
            tick(1);
        end

        btn_clean = '0;
        evt_ready = 1'b1;
        tick(200);
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
